bf16_classify: RTL and testbench
================================

// Module: bf16_classify
// PURPOSE
//  Registered operand classifier for bfloat16 values (1 sign, 8 exponent, 7 mantissa bits).
//  Sits in front of the FPU add/sub datapath.
//  Flags special operands (+Inf, -Inf, NaN, zero, subnormal, normal) so the arithmetic
//  path can bypass or force results, e.g. canonical NaN 16'h7FC0, +Inf 16'h7F80, -Inf 16'hFF80.
//  One operand per cycle, fixed latency of one clock.
// PARAMETERS
//  none (format fixed: EXP_W=8, MAN_W=7, total 16 bits)
// PORTS
//  clk_i       in   1   clock, rising edge
//  rst_ni      in   1   synchronous active-low reset
//  valid_i     in   1   num_i is valid this cycle
//  num_i       in   16  bfloat16 operand {sign, exp[7:0], man[6:0]}
//  valid_o     out  1   registered valid_i; flags below belong to this sample
//  inf_o       out  1   +Infinity
//  neg_inf_o   out  1   -Infinity
//  nan_o       out  1   NaN of either sign
//  snan_o      out  1   signalling NaN
//  zero_o      out  1   +0 or -0
//  sub_norm_o  out  1   subnormal, either sign
//  normal_o    out  1   normal, either sign
//  sign_o      out  1   registered sign bit of the sample
// BEHAVIOUR
//  - Interface: one clock and a synchronous, active-low reset; clk_i and rst_ni.
//  - Decode, with e=num_i[14:7], m=num_i[6:0], s=num_i[15]:
//      e==8'hFF & m==0 : s ? neg_inf_o : inf_o
//      e==8'hFF & m!=0 : nan_o; snan_o = ~m[6] (quiet NaN has m[6]=1)
//      e==0 & m==0     : zero_o
//      e==0 & m!=0     : sub_norm_o
//      otherwise       : normal_o
//  - Exactly one of {inf,neg_inf,nan,zero,sub_norm,normal} is 1 whenever valid_o=1.
//  - snan_o implies nan_o.
//  - Latency 1: flags sampled at edge N are visible after edge N, with valid_o=1.
//  - valid_i=0: valid_o<=0 and all flags <=0.
//    Flags are never held stale; outputs are all-zero when valid_o=0.
//  - No handshake or backpressure: a new sample is accepted every cycle.
//  - Reset (rst_ni=0 at a rising edge): all outputs <=0, including valid_o and sign_o.
//    Reset overrides valid_i in the same cycle.
//    An in-flight sample is dropped when reset is asserted mid-stream.
//  - No internal state beyond the output registers.
// CONFIGURATION
//  BF16_CLASSIFY_FCLASS_EN defined: adds output port fclass_o[9:0], registered with the flags.
//    It is a RISC-V FCLASS one-hot mask:
//    bit0 -inf, 1 -normal, 2 -subnormal, 3 -0, 4 +0, 5 +subnormal, 6 +normal,
//    7 +inf, 8 sNaN, 9 qNaN.
//    It reads all-zero when valid_o=0 or in reset.
//  Macro undefined: the port and its logic are absent; all other behaviour is identical.
// TESTING
//  - Reset with rst_ni=0 and valid_i=1, num_i=16'h7F80 -> next cycle all outputs 0.
//  - Specials with valid_i=1:
//      16'h7F80 -> inf_o; 16'hFF80 -> neg_inf_o.
//      16'h7FC0 -> nan_o, snan_o=0; 16'hFF81 -> nan_o, snan_o=1.
//  - Zero and subnormal:
//      16'h0000 and 16'h8000 -> zero_o, sign_o 0/1.
//      16'h0001 and 16'h807F -> sub_norm_o.
//  - Normals:
//      16'h3F80 (1.0) and 16'hC000 (-2.0) -> normal_o only.
//      16'h7F7F (max finite) -> normal_o.
//  - Streaming: back-to-back 16'h3F80, 16'h7F80, 16'h0000 -> flags change every cycle,
//    each one cycle late; dropping valid_i -> outputs 0 next cycle.
//  - With BF16_CLASSIFY_FCLASS_EN:
//      16'hFF80 -> fclass_o=10'h001; 16'h7FC0 -> 10'h200; 16'h0000 -> 10'h010.
//    Also sweep all 65536 codes and check the one-hot invariant.

Source files
------------

// File: rtl/bf16_classify.sv
// Registered bfloat16 operand classifier, one sample per clock, latency 1.
// Define BF16_CLASSIFY_FCLASS_EN to add the RISC-V FCLASS mask output fclass_o.
module bf16_classify (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        valid_i,
  input  logic [15:0] num_i,
  output logic        valid_o,
  output logic        inf_o,
  output logic        neg_inf_o,
  output logic        nan_o,
  output logic        snan_o,
  output logic        zero_o,
  output logic        sub_norm_o,
  output logic        normal_o,
  output logic        sign_o
`ifdef BF16_CLASSIFY_FCLASS_EN
  ,
  output logic [9:0]  fclass_o
`endif
);

  logic       s;
  logic [7:0] e;
  logic [6:0] m;
  logic       exp_max;
  logic       exp_zero;
  logic       man_zero;

  assign s        = num_i[15];
  assign e        = num_i[14:7];
  assign m        = num_i[6:0];
  assign exp_max  = &e;
  assign exp_zero = ~|e;
  assign man_zero = ~|m;

  logic c_inf;
  logic c_ninf;
  logic c_nan;
  logic c_snan;
  logic c_zero;
  logic c_sub;
  logic c_norm;

  always_comb begin
    c_inf  = 1'b0;
    c_ninf = 1'b0;
    c_nan  = 1'b0;
    c_snan = 1'b0;
    c_zero = 1'b0;
    c_sub  = 1'b0;
    c_norm = 1'b0;
    unique case (1'b1)
      exp_max & man_zero: begin
        c_inf  = ~s;
        c_ninf = s;
      end
      exp_max & ~man_zero: begin
        c_nan  = 1'b1;
        c_snan = ~m[6];
      end
      exp_zero & man_zero:  c_zero = 1'b1;
      exp_zero & ~man_zero: c_sub  = 1'b1;
      default:              c_norm = 1'b1;
    endcase
  end

`ifdef BF16_CLASSIFY_FCLASS_EN
  logic [9:0] c_fclass;

  always_comb begin
    c_fclass    = '0;
    c_fclass[0] = c_ninf;
    c_fclass[1] = c_norm & s;
    c_fclass[2] = c_sub & s;
    c_fclass[3] = c_zero & s;
    c_fclass[4] = c_zero & ~s;
    c_fclass[5] = c_sub & ~s;
    c_fclass[6] = c_norm & ~s;
    c_fclass[7] = c_inf;
    c_fclass[8] = c_snan;
    c_fclass[9] = c_nan & ~c_snan;
  end
`endif

  // Invalid cycles clear everything so flags never go stale.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || !valid_i) begin
      valid_o    <= 1'b0;
      inf_o      <= 1'b0;
      neg_inf_o  <= 1'b0;
      nan_o      <= 1'b0;
      snan_o     <= 1'b0;
      zero_o     <= 1'b0;
      sub_norm_o <= 1'b0;
      normal_o   <= 1'b0;
      sign_o     <= 1'b0;
`ifdef BF16_CLASSIFY_FCLASS_EN
      fclass_o   <= '0;
`endif
    end else begin
      valid_o    <= 1'b1;
      inf_o      <= c_inf;
      neg_inf_o  <= c_ninf;
      nan_o      <= c_nan;
      snan_o     <= c_snan;
      zero_o     <= c_zero;
      sub_norm_o <= c_sub;
      normal_o   <= c_norm;
      sign_o     <= s;
`ifdef BF16_CLASSIFY_FCLASS_EN
      fclass_o   <= c_fclass;
`endif
    end
  end

endmodule

// File: tb/tb_bf16_classify.sv
// Scoreboard bench for bf16_classify: driver queues expectations,
// monitor pops and compares one cycle after each sample edge.
module tb_bf16_classify;

  logic        clk;
  logic        rst_n;
  logic        valid_i;
  logic [15:0] num;
  logic        valid_o;
  logic        inf_o;
  logic        neg_inf_o;
  logic        nan_o;
  logic        snan_o;
  logic        zero_o;
  logic        sub_norm_o;
  logic        normal_o;
  logic        sign_o;
  logic [9:0]  fclass;

  bf16_classify dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .valid_i    (valid_i),
    .num_i      (num),
    .valid_o    (valid_o),
    .inf_o      (inf_o),
    .neg_inf_o  (neg_inf_o),
    .nan_o      (nan_o),
    .snan_o     (snan_o),
    .zero_o     (zero_o),
    .sub_norm_o (sub_norm_o),
    .normal_o   (normal_o),
    .sign_o     (sign_o)
`ifdef BF16_CLASSIFY_FCLASS_EN
    ,
    .fclass_o   (fclass)
`endif
  );

`ifndef BF16_CLASSIFY_FCLASS_EN
  assign fclass = '0;
`endif

  // {valid, inf, ninf, nan, snan, zero, sub, norm, sign}
  localparam logic [8:0] V    = 9'h100;
  localparam logic [8:0] INF  = 9'h080;
  localparam logic [8:0] NINF = 9'h040;
  localparam logic [8:0] NAN  = 9'h020;
  localparam logic [8:0] SNAN = 9'h010;
  localparam logic [8:0] ZERO = 9'h008;
  localparam logic [8:0] SUB  = 9'h004;
  localparam logic [8:0] NORM = 9'h002;
  localparam logic [8:0] SGN  = 9'h001;

  typedef struct {
    string      name;
    logic [8:0] flags;
    logic [9:0] fc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input string nm, input logic r, input logic v,
                       input logic [15:0] n, input logic [8:0] f,
                       input logic [9:0] fc);
    exp_t x;
    @(negedge clk);
    rst_n   = r;
    valid_i = v;
    num     = n;
    x.name  = nm;
    x.flags = f;
    x.fc    = fc;
    q.push_back(x);
  endtask

  // Independent reference using magnitude comparisons.
  function automatic exp_t model(input logic [15:0] n);
    exp_t       x;
    logic [14:0] mag;
    logic        s;
    mag = n[14:0];
    s   = n[15];
    x.name = "sweep";
    x.fc   = '0;
    if (mag > 15'h7F80) begin
      x.flags = V | NAN;
      if (mag < 15'h7FC0) begin
        x.flags = x.flags | SNAN;
        x.fc[8] = 1'b1;
      end else begin
        x.fc[9] = 1'b1;
      end
    end else if (mag == 15'h7F80) begin
      x.flags = s ? (V | NINF) : (V | INF);
      x.fc    = s ? 10'h001 : 10'h080;
    end else if (mag == 15'h0000) begin
      x.flags = V | ZERO;
      x.fc    = s ? 10'h008 : 10'h010;
    end else if (mag < 15'h0080) begin
      x.flags = V | SUB;
      x.fc    = s ? 10'h004 : 10'h020;
    end else begin
      x.flags = V | NORM;
      x.fc    = s ? 10'h002 : 10'h040;
    end
    if (s) x.flags = x.flags | SGN;
    return x;
  endfunction

  logic [8:0] obs;
  assign obs = {valid_o, inf_o, neg_inf_o, nan_o, snan_o,
                zero_o, sub_norm_o, normal_o, sign_o};

  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        checks++;
        if (obs !== x.flags) begin
          errors++;
          $display("FAIL %s flags got %h want %h", x.name, obs, x.flags);
        end
`ifdef BF16_CLASSIFY_FCLASS_EN
        checks++;
        if (fclass !== x.fc) begin
          errors++;
          $display("FAIL %s fclass got %h want %h", x.name, fclass, x.fc);
        end
`endif
        if (valid_o === 1'b1) begin
          checks++;
          if ($countones({inf_o, neg_inf_o, nan_o, zero_o,
                          sub_norm_o, normal_o}) != 1 ||
              (snan_o && !nan_o)) begin
            errors++;
            $display("FAIL %s onehot got %h want one class", x.name, obs);
          end
        end
      end
    end
  end

  initial begin
    exp_t m;
    int   wait_cyc;
    rst_n   = 1'b0;
    valid_i = 1'b1;
    num     = 16'h7F80;
    drive("rst0", 1'b0, 1'b1, 16'h7F80, 9'h000, 10'h000);
    drive("rst1", 1'b0, 1'b1, 16'h7F80, 9'h000, 10'h000);
    drive("pinf", 1'b1, 1'b1, 16'h7F80, V | INF, 10'h080);
    drive("ninf", 1'b1, 1'b1, 16'hFF80, V | NINF | SGN, 10'h001);
    drive("qnan", 1'b1, 1'b1, 16'h7FC0, V | NAN, 10'h200);
    drive("snan", 1'b1, 1'b1, 16'hFF81, V | NAN | SNAN | SGN, 10'h100);
    drive("pzero", 1'b1, 1'b1, 16'h0000, V | ZERO, 10'h010);
    drive("nzero", 1'b1, 1'b1, 16'h8000, V | ZERO | SGN, 10'h008);
    drive("psub", 1'b1, 1'b1, 16'h0001, V | SUB, 10'h020);
    drive("nsub", 1'b1, 1'b1, 16'h807F, V | SUB | SGN, 10'h004);
    drive("one", 1'b1, 1'b1, 16'h3F80, V | NORM, 10'h040);
    drive("mtwo", 1'b1, 1'b1, 16'hC000, V | NORM | SGN, 10'h002);
    drive("maxf", 1'b1, 1'b1, 16'h7F7F, V | NORM, 10'h040);
    drive("minn", 1'b1, 1'b1, 16'h0080, V | NORM, 10'h040);
    drive("idle", 1'b1, 1'b0, 16'hFF80, 9'h000, 10'h000);
    drive("st0", 1'b1, 1'b1, 16'h3F80, V | NORM, 10'h040);
    drive("st1", 1'b1, 1'b1, 16'h7F80, V | INF, 10'h080);
    drive("st2", 1'b1, 1'b1, 16'h0000, V | ZERO, 10'h010);
    drive("stoff", 1'b1, 1'b0, 16'h0000, 9'h000, 10'h000);
    drive("st3", 1'b1, 1'b1, 16'hFFC1, V | NAN | SGN, 10'h200);
    drive("midrst", 1'b0, 1'b1, 16'h7FC0, 9'h000, 10'h000);
    drive("after", 1'b1, 1'b1, 16'h8001, V | SUB | SGN, 10'h004);
`ifdef BF16_CLASSIFY_FCLASS_EN
    for (int i = 0; i < 65536; i++) begin
      m = model(16'(i));
      drive(m.name, 1'b1, 1'b1, 16'(i), m.flags, m.fc);
    end
`endif
    drive("tail", 1'b1, 1'b0, 16'h0000, 9'h000, 10'h000);
    wait_cyc = 0;
    while (q.size() > 0 && wait_cyc < 10) begin
      @(posedge clk);
      wait_cyc++;
    end
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d left want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
